// File: rtl/rs_gen_pkg.sv
`default_nettype none
// rs_gen_pkg: shared data word width, ready-tag value and opcode encodings
// used by the reservation station and its entry picker.
package rs_gen_pkg;

   localparam int WORD_W       = 32;
   localparam int ZERO_ROB_IDX = 0;

   localparam logic [5:0] OPT_NONE = 6'h00;

endpackage
`default_nettype wire

// File: rtl/rs_pick.sv
`default_nettype none
// rs_pick: chooses one ready reservation-station entry for dispatch.
// RS_OLDEST_FIRST_EN selects oldest-by-issue via an age matrix; otherwise lowest index wins.
module rs_pick
   import rs_gen_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IDX_W = $clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             push,
   input  logic [IDX_W-1:0] push_idx,
   input  logic [DEPTH-1:0] ready,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [DEPTH-1:0] win;

`ifdef RS_OLDEST_FIRST_EN
   // age[i][j] set means entry i was issued before entry j
   logic [DEPTH-1:0] age [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      end else if (en && push) begin
         for (int j = 0; j < DEPTH; j++) begin
            age[j][push_idx] <= (IDX_W'(j) != push_idx);
         end
         age[push_idx] <= '0;
      end
   end

   always_comb begin
      win = '0;
      for (int i = 0; i < DEPTH; i++) begin
         win[i] = ready[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && ready[j] && !age[i][j]) win[i] = 1'b0;
         end
      end
   end
`else
   logic unused_pick;
   assign unused_pick = ^{clk, rst, en, push, push_idx};
   assign win         = ready;
`endif

   always_comb begin
      any = |win;
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (win[i]) idx = IDX_W'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/rs_gen.sv
`default_nettype none
// rs_gen: reservation station with issue-time CDB capture, CDB wakeup and a registered ALU port.
// Define RS_OLDEST_FIRST_EN to dispatch oldest-ready instead of lowest-index-ready.
module rs_gen
   import rs_gen_pkg::*;
#(
   parameter int DEPTH       = 16,
   parameter int NCDB        = 2,
   parameter int ROB_W       = 4,
   parameter int OPT_W       = 6,
   parameter int FULL_MARGIN = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   stall,
   input  logic                   flush,
   output logic                   full,
   output logic                   empty,
   output logic                   err,
   input  logic                   id_valid,
   input  logic [OPT_W-1:0]       id_opt,
   input  logic [ROB_W-1:0]       id_src1,
   input  logic [ROB_W-1:0]       id_src2,
   input  logic [WORD_W-1:0]      id_val1,
   input  logic [WORD_W-1:0]      id_val2,
   input  logic [WORD_W-1:0]      id_imm,
   input  logic [ROB_W-1:0]       id_rob_idx,
   output logic                   alu_valid,
   output logic [OPT_W-1:0]       alu_opt,
   output logic [WORD_W-1:0]      alu_val1,
   output logic [WORD_W-1:0]      alu_val2,
   output logic [WORD_W-1:0]      alu_imm,
   output logic [ROB_W-1:0]       alu_rob_idx,
   input  logic                   alu_ready,
   input  logic [NCDB-1:0]        cdb_valid,
   input  logic [NCDB*ROB_W-1:0]  cdb_src,
   input  logic [NCDB*WORD_W-1:0] cdb_val
);

   localparam int               IDX_W    = $clog2(DEPTH);
   localparam int               CNT_W    = IDX_W + 1;
   localparam logic [ROB_W-1:0] TAG_ZERO = ROB_W'(ZERO_ROB_IDX);

   logic [DEPTH-1:0]              busy;
   logic [DEPTH-1:0][OPT_W-1:0]   e_opt;
   logic [DEPTH-1:0][ROB_W-1:0]   e_tag1, e_tag2, e_rob;
   logic [DEPTH-1:0][WORD_W-1:0]  e_val1, e_val2, e_imm;
   logic [CNT_W-1:0]              count;

   logic             active, push, pop, pick_any;
   logic [IDX_W-1:0] free_idx, pick_idx;
   logic [DEPTH-1:0] ready;
   logic             hit1, hit2;
   logic [WORD_W-1:0] cap1, cap2;

   assign active = rdy && !stall;
   assign push   = active && id_valid && (count < CNT_W'(DEPTH));
   assign pop    = active && pick_any && (!alu_valid || alu_ready);
   assign full   = count >= CNT_W'(DEPTH - FULL_MARGIN);
   assign empty  = count == '0;

   always_comb begin
      free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) free_idx = IDX_W'(i);
      end
   end

   always_comb begin
      ready = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ready[i] = busy[i] && (e_tag1[i] == TAG_ZERO) && (e_tag2[i] == TAG_ZERO);
      end
   end

   // Descending scan so the lowest-numbered matching CDB port wins.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      cap1 = id_val1;
      cap2 = id_val2;
      for (int k = NCDB - 1; k >= 0; k--) begin
         if (cdb_valid[k] && id_src1 != TAG_ZERO && cdb_src[k*ROB_W +: ROB_W] == id_src1) begin
            hit1 = 1'b1;
            cap1 = cdb_val[k*WORD_W +: WORD_W];
         end
         if (cdb_valid[k] && id_src2 != TAG_ZERO && cdb_src[k*ROB_W +: ROB_W] == id_src2) begin
            hit2 = 1'b1;
            cap2 = cdb_val[k*WORD_W +: WORD_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy      <= '0;
         count     <= '0;
         alu_valid <= 1'b0;
         alu_opt   <= OPT_W'(OPT_NONE);
         e_tag1    <= '0;
         e_tag2    <= '0;
         if (rst) err <= 1'b0;
      end else if (active) begin
         if (id_valid && count == CNT_W'(DEPTH)) err <= 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);

         // Later (lower k) iterations override earlier ones, giving port 0 priority.
         for (int i = 0; i < DEPTH; i++) begin
            for (int k = NCDB - 1; k >= 0; k--) begin
               if (busy[i] && cdb_valid[k] && e_tag1[i] != TAG_ZERO &&
                   cdb_src[k*ROB_W +: ROB_W] == e_tag1[i]) begin
                  e_tag1[i] <= TAG_ZERO;
                  e_val1[i] <= cdb_val[k*WORD_W +: WORD_W];
               end
               if (busy[i] && cdb_valid[k] && e_tag2[i] != TAG_ZERO &&
                   cdb_src[k*ROB_W +: ROB_W] == e_tag2[i]) begin
                  e_tag2[i] <= TAG_ZERO;
                  e_val2[i] <= cdb_val[k*WORD_W +: WORD_W];
               end
            end
         end

         if (push) begin
            busy[free_idx]   <= 1'b1;
            e_opt[free_idx]  <= id_opt;
            e_tag1[free_idx] <= hit1 ? TAG_ZERO : id_src1;
            e_tag2[free_idx] <= hit2 ? TAG_ZERO : id_src2;
            e_val1[free_idx] <= cap1;
            e_val2[free_idx] <= cap2;
            e_imm[free_idx]  <= id_imm;
            e_rob[free_idx]  <= id_rob_idx;
         end

         if (pop) begin
            busy[pick_idx] <= 1'b0;
            alu_valid      <= 1'b1;
            alu_opt        <= e_opt[pick_idx];
            alu_val1       <= e_val1[pick_idx];
            alu_val2       <= e_val2[pick_idx];
            alu_imm        <= e_imm[pick_idx];
            alu_rob_idx    <= e_rob[pick_idx];
         end else if (alu_ready) begin
            alu_valid <= 1'b0;
         end
      end
   end

   rs_pick #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_pick (
      .clk      (clk),
      .rst      (rst || flush),
      .en       (active),
      .push     (push),
      .push_idx (free_idx),
      .ready    (ready),
      .any      (pick_any),
      .idx      (pick_idx)
   );

endmodule
`default_nettype wire

// File: doc/rs_gen.md
RS_GEN -- requirements
Module: rs_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning entry count (power of two, 4..64).
REQ-002 SHALL have parameter NCDB, default 2, meaning number of CDB broadcast ports.
REQ-003 SHALL have parameter ROB_W, default 4, meaning ROB tag width; tag 0 means operand ready.
REQ-004 SHALL have parameter OPT_W, default 6, meaning opcode width.
REQ-005 SHALL have parameter FULL_MARGIN, default 4, meaning almost-full slack.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-008 SHALL have ports rdy / stall / flush, input, 1 each: global ready / hold / rollback.
REQ-009 SHALL have ports full / empty / err, output, 1 each: almost-full / empty / sticky overflow.
REQ-010 SHALL have issue inputs: id_valid 1; id_opt OPT_W; id_src1, id_src2 ROB_W; id_val1, id_val2, id_imm 32; id_rob_idx ROB_W.
REQ-011 SHALL have dispatch outputs alu_valid 1, alu_opt OPT_W, alu_val1, alu_val2, alu_imm 32, alu_rob_idx ROB_W, and input alu_ready 1.
REQ-012 SHALL have CDB inputs cdb_valid NCDB, cdb_src NCDB*ROB_W, cdb_val NCDB*32; port k occupies slice k.

Function
REQ-013 SHALL keep count = exact occupancy, updated per edge as count + push - pop; full = count >= DEPTH-FULL_MARGIN; empty = count==0.
REQ-014 SHALL, on id_valid with count<DEPTH, write the lowest-index free entry and set busy.
REQ-015 SHALL, on id_valid with count==DEPTH, discard the issue and set err until rst.
REQ-016 SHALL capture CDB matches at issue: if id_srcN matches any valid cdb_src, store tag 0 and that port's value.
REQ-017 SHALL, for each busy entry and CDB port k with cdb_valid[k] and nonzero matching tag, clear the tag and load cdb_val[k].
REQ-018 SHALL resolve multiple CDB ports carrying the same tag by taking the lowest port index.
REQ-019 SHALL treat an entry as ready when busy and both tags are 0; a newly written entry SHALL NOT dispatch in its write cycle.
REQ-020 SHALL load the output register and free the entry when any entry is ready and (!alu_valid || alu_ready).
REQ-021 SHALL hold the output register stable while alu_valid && !alu_ready.
REQ-022 SHALL deassert alu_valid on alu_ready when no entry is ready.
REQ-023 SHALL, when ready-to-use conditions hold, dispatch no earlier than the edge after the write edge (1-cycle minimum latency).
REQ-024 SHALL freeze all state, including issue, wakeup and dispatch, while !rdy || stall.
REQ-025 SHALL allow push and pop in the same cycle, leaving count unchanged.

Reset
REQ-026 SHALL, on rst or flush, clear busy, count, alu_valid, and all tags to 0.
REQ-027 SHALL clear err on rst only; flush SHALL NOT clear it.
REQ-028 SHALL give rst and flush priority over rdy and stall.

Configuration
REQ-029 SHALL, with RS_OLDEST_FIRST_EN defined, select the oldest ready entry by issue order using a DEPTH x DEPTH age matrix.
REQ-030 SHALL, without RS_OLDEST_FIRST_EN, select the lowest-index ready entry and omit the age matrix.

Structure
REQ-031 SHALL take word width, ZERO_ROB_IDX, and opcode encodings (OPT_NONE etc.) from the shared package; SHALL NOT define local copies.
REQ-032 SHALL place ready-entry selection in a sub-module named rs_pick, which contains the age matrix or the priority encoder.

Verification
REQ-033 SHALL verify: issue src1=0, src2=0, val 5/7 at cycle 0 -> alu_valid=1 after edge 1, alu_val1=5, alu_val2=7; count back to 0.
REQ-034 SHALL verify: issue id_src1=3 while cdb_valid[1]=1, cdb_src[1]=3, cdb_val[1]=0xAB -> entry stored ready; alu_val1=0xAB.
REQ-035 SHALL verify: fill 16 entries with src1=2 -> full=1 from count 12; a 17th issue leaves count=16 and sets err=1; a broadcast of tag 2 drains one entry per cycle.
REQ-036 SHALL verify: alu_ready=0 for 3 cycles with alu_valid=1 -> outputs held constant and the entry not double-dispatched.
REQ-037 SHALL verify: with RS_OLDEST_FIRST_EN, issue A to slot 1 and B to slot 0 after A leaves slot 0, wake both together -> A dispatches first; without the macro, B (slot 0) dispatches first.
REQ-038 SHALL verify: flush with 5 busy entries and alu_valid=1 -> next cycle count=0, empty=1, alu_valid=0, err unchanged.
